mux_rr_arbiter: RTL
===================

# mux_rr_arbiter

Round-robin arbiter that shares the team's 4:1 `mux` between four requesters (A–D). It grants one requester at a time, drives the mux `sel`, and streams that requester's data through a valid/ready output handshake. Each grant is held for a burst of up to `MAX_BURST` accepted beats. The block sits between four producer blocks and a single downstream consumer.

## Interface
Parameters:
- `WIDTH`, default 8: data width of every requester and of `out_data`.
- `MAX_BURST`, default 4: maximum number of beats accepted per grant. Legal range is ≥1.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `req`, in, 4: request lines; bit 0 is A, bit 1 is B, bit 2 is C, bit 3 is D.
- `data_a`/`data_b`/`data_c`/`data_d`, in, WIDTH each: requester data.
- `out_ready`, in, 1: downstream consumer can accept a beat.
- `out_data`, out, WIDTH: selected requester's data, taken from the mux.
- `out_valid`, out, 1: `out_data` holds a valid beat this cycle.
- `grant`, out, 4: one-hot registered grant; all zero when idle.
- `sel`, out, 2: registered mux select (00=A, 01=B, 10=C, 11=D).
- `busy`, out, 1: high in state GRANT.

## Operation
- **States:** IDLE and GRANT.
- **Registers:** `state`, `sel`, `grant`, `last` (2-bit index of the last granted requester), and `beats` (width clog2(MAX_BURST+1)).
- **IDLE:**
  - If `req` is nonzero, pick the first set bit scanning `last+1`, `last+2`, `last+3`, `last` (mod 4).
  - Load `sel` and `grant` with the winner, set `last` to the winner, clear `beats`, and go to GRANT.
  - If `req` is zero, stay in IDLE. `grant`, `sel` and `last` keep their values, except that `grant` stays 0.
- **GRANT:**
  - `out_valid = req[sel]`, combinational.
  - A beat is accepted when `out_valid && out_ready`; each accepted beat increments `beats`.
  - Exit to IDLE at the next edge if either condition holds:
    - (a) `req[sel]` is low this cycle. The requester has withdrawn.
    - (b) A beat is accepted this cycle and `beats == MAX_BURST-1`. The burst is complete.
  - On exit, `grant` is cleared. `sel` holds its value.
  - `out_valid` low with `out_ready` high is not a beat.
- **Datapath:** `out_data` always equals the `data_*` input chosen by `sel`, through the `mux`. The value is meaningful only while `out_valid` is high.
- **Fairness:** after a burst ends, the just-served requester has the lowest priority. With all four requesting, grants go A, B, C, D, A, …
- **Reset values:**
  - `state` = IDLE, `grant` = 0000, `sel` = 00, `last` = 11 (so A has first priority), `beats` = 0.
  - `out_valid` = 0 and `busy` = 0.
- **Reset mid-burst:** all registers go to their reset values immediately, whatever the handshake state. No beat is accepted while `reset` is high.
- **`MAX_BURST` = 1:** every grant carries exactly one beat.

## Timing
- **Grant latency:** `req` sampled high in IDLE at edge n gives `grant`/`sel`/`busy` valid after edge n; the first possible beat is in cycle n+1.
- **Re-arbitration:** leaving GRANT always passes through one IDLE cycle. The best-case sustained throughput is therefore MAX_BURST beats per MAX_BURST+1 cycles.
- **Combinational paths:** `out_valid` is combinational from `req` and registered state. `out_data` is combinational from `data_*` through the mux. There is no path from `out_ready` to `out_valid`.
- **Simultaneous events:** if `req[sel]` drops in the same cycle the last beat would be accepted, no beat is accepted (`out_valid` is 0) and the block exits through rule (a).
- **New requests during GRANT:** they are ignored until the next IDLE cycle.

## Structure
- **Shared package `mux_arb_pkg`:**
  - state enum `{IDLE, GRANT}`.
  - `NUM_REQ` = 4.
  - `SEL_A`..`SEL_D` 2-bit select constants.
- **Sub-module:** one instance of the existing `mux` (`WIDTH` passed through), with `sel` connected and `enable` tied to `busy`.
- **Split:** the arbiter FSM and the rotate-priority encoder live in this module. Expected size is about 150 RTL lines.

## Test plan
- **Reset:** assert `reset` with `req`=1111. Required: `grant`=0000, `sel`=00, `out_valid`=0. After release, the first edge grants A (`grant`=0001).
- **Round-robin:** `req`=1111 held, `out_ready`=1, `MAX_BURST`=4. Required: grants A, B, C, D, A, each with 4 beats and one IDLE cycle between grants. `out_data` matches `data_a`=8'h11, `data_b`=8'h22, `data_c`=8'h33, `data_d`=8'h44.
- **Backpressure:** C granted, `out_ready` toggles 1,0,0,1,1,1. Required: exactly 4 beats counted, on the ready-high cycles only; then the block exits to IDLE.
- **Withdrawal:** B granted; after 2 beats `req[1]` drops. Required: `out_valid`=0 that cycle, IDLE next, and the next grant goes to C if `req[2]`=1.
- **Reset mid-burst:** assert `reset` asynchronously during D's second beat. Required: `grant`=0000 and `busy`=0 immediately; after release, A is granted first.
- **Corner case:** `MAX_BURST`=1 with `req`=1010. Required: grant sequence B, D, B, D, each with exactly 1 beat.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types and constants for the round-robin mux arbiter
package mux_arb_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam int NUM_REQ = 4;
  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;
  localparam logic [1:0] SEL_D = 2'd3;
endpackage

// File: rtl/mux.sv
// mux: 4:1 data selector with output enable, zero when disabled
module mux #(
  parameter int WIDTH = 8
) (
  input  logic             enable,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] y
);
  // pick the selected input, gated by enable
  always_comb y = !enable ? '0 : sel == 2'd0 ? d0 : sel == 2'd1 ? d1 : sel == 2'd2 ? d2 : d3;
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin burst arbiter sharing a 4:1 mux among four requesters
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] data_c,
  input  logic [WIDTH-1:0] data_d,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [3:0]       grant,
  output logic [1:0]       sel,
  output logic             busy
);
  localparam int BW = $clog2(MAX_BURST + 1);
  state_t state;
  logic [1:0] last;
  logic [1:0] win;
  logic [BW-1:0] beats;
  logic accept;
  logic done;
  assign busy = state == GRANT;
  assign out_valid = busy && req[sel];
  assign accept = out_valid && out_ready;
  assign done = accept && beats == BW'(MAX_BURST - 1);
  // rotate-priority pick: first requester after last, wrapping, last one lowest
  always_comb begin
    win = last;
    for (int i = NUM_REQ; i >= 1; i--)
      if (req[2'(last + 2'(i))]) win = 2'(last + 2'(i));
  end
  // arbiter FSM: grant on request in IDLE, release on withdrawal or full burst
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      sel   <= SEL_A;
      last  <= SEL_D;
      beats <= '0;
    end else if (state == IDLE) begin
      grant <= '0;
      if (|req) begin
        state <= GRANT;
        sel   <= win;
        grant <= 4'b0001 << win;
        last  <= win;
        beats <= '0;
      end
    end else begin
      if (accept) beats <= beats + 1'b1;
      if (!req[sel] || done) begin
        state <= IDLE;
        grant <= '0;
      end
    end
  end
  mux #(.WIDTH(WIDTH)) u_mux (
    .enable(busy),
    .sel   (sel),
    .d0    (data_a),
    .d1    (data_b),
    .d2    (data_c),
    .d3    (data_d),
    .y     (out_data)
  );
endmodule
